// File: rtl/led_mmio_ctrl.sv
// Memory-mapped LED peripheral: static pattern, per-bit blink and optional PWM dimming.
// Optional feature macro: LED_PWM_EN (adds the 8-bit PWM dimmer behind register 3).
module led_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          PERIOD_W  = 24
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        write_en,
  input  logic        read_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [7:0]  led
);

  logic [7:0]          led_data;
  logic [7:0]          blink_mask;
  logic [PERIOD_W-1:0] blink_period;
  logic [PERIOD_W-1:0] blink_cnt;
  logic                phase_on;
  logic [7:0]          pwm_duty_rd;

  logic [31:0] offset;
  logic [1:0]  idx;
  logic        accept;
  logic        wr_acc;
  logic [31:0] rd_val;
  logic [7:0]  base;
  logic [7:0]  led_next;
  logic        unused_wdata;

  assign offset = addr - BASE_ADDR;
  assign idx    = offset[1:0];
  // ready is high in the cycle after an accept, which keeps a held request from being taken twice
  assign accept = (offset < 32'd4) && (write_en || read_en) && !ready;
  assign wr_acc = accept && write_en;
  assign unused_wdata = ^wdata[31:8];

  assign base = led_data & ~(blink_mask & {8{~phase_on}});

`ifdef LED_PWM_EN
  logic [7:0] pwm_duty;
  logic [7:0] pwm_cnt;
  logic       pwm_on;

  assign pwm_duty_rd = pwm_duty;
  assign pwm_on      = (pwm_duty == 8'hFF) || (pwm_cnt < pwm_duty);
  assign led_next    = base & {8{pwm_on}};

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      pwm_duty <= 8'hFF;
      pwm_cnt  <= 8'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (wr_acc && idx == 2'd3) pwm_duty <= wdata[7:0];
    end
  end
`else
  assign pwm_duty_rd = 8'hFF;
  assign led_next    = base;
`endif

  always_comb begin
    rd_val = 32'd0;
    case (idx)
      2'd0:    rd_val = {24'd0, led_data};
      2'd1:    rd_val = {24'd0, blink_mask};
      2'd2:    rd_val = {{(32-PERIOD_W){1'b0}}, blink_period};
      default: rd_val = {24'd0, pwm_duty_rd};
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      led_data     <= 8'd0;
      blink_mask   <= 8'd0;
      blink_period <= '0;
      blink_cnt    <= '0;
      phase_on     <= 1'b1;
      ready        <= 1'b0;
      rdata        <= 32'd0;
      led          <= 8'd0;
    end else begin
      ready <= accept;
      rdata <= accept ? rd_val : 32'd0;

      if (wr_acc && idx == 2'd0) led_data   <= wdata[7:0];
      if (wr_acc && idx == 2'd1) blink_mask <= wdata[7:0];

      // Period write restarts the blink in the ON phase; >= lets a shortened period wrap at once
      if (wr_acc && idx == 2'd2) begin
        blink_period <= wdata[PERIOD_W-1:0];
        blink_cnt    <= '0;
        phase_on     <= 1'b1;
      end else if (blink_period == '0) begin
        blink_cnt <= '0;
        phase_on  <= 1'b1;
      end else if (blink_cnt >= blink_period - 1'b1) begin
        blink_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      led <= led_next;
    end
  end

endmodule

// File: tb/tb_led_mmio_ctrl.sv
// Directed bench for led_mmio_ctrl: reset, handshake, register map, blink timing, PWM/duty, reset abort.
module tb_led_mmio_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        write_en;
  logic        read_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [7:0]  led;

  int vectors;
  int miscompares;

  led_mmio_ctrl dut (
    .clk_25mhz (clk),
    .reset     (reset),
    .addr      (addr),
    .write_en  (write_en),
    .read_en   (read_en),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .led       (led)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Drive a request 1 time unit after an edge, hold it until ready (bounded), then release.
  task automatic bus_op(input logic [31:0] a, input logic we, input logic re,
                        input logic [31:0] wd, output logic got, output logic [31:0] rd);
    addr = a; write_en = we; read_en = re; wdata = wd;
    got = 1'b0; rd = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        got = 1'b1;
        rd  = rdata;
        break;
      end
    end
    write_en = 1'b0; read_en = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic test_reset();
    logic got; logic [31:0] rd;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    vectors++;
    if (led !== 8'h00) begin miscompares++; $display("FAIL reset_led: got %h want 00", led); end
    vectors++;
    if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", ready); end
    vectors++;
    if (rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    bus_op(32'h8000_0003, 1'b0, 1'b1, 32'd0, got, rd);
    vectors++;
    if (got !== 1'b1 || rd !== 32'h0000_00FF) begin
      miscompares++; $display("FAIL reset_duty_read: ready %b rdata %h want 1/000000ff", got, rd);
    end
  endtask

  task automatic test_store();
    logic got; logic [31:0] rd;
    bus_op(32'h8000_0000, 1'b1, 1'b0, 32'h0000_01A5, got, rd);
    vectors++;
    if (got !== 1'b1) begin miscompares++; $display("FAIL store_ready: got %b want 1", got); end
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b0) begin miscompares++; $display("FAIL store_ready_pulse: got %b want 0", ready); end
    vectors++;
    if (led !== 8'hA5) begin miscompares++; $display("FAIL store_led: got %h want a5", led); end
    bus_op(32'h8000_0000, 1'b0, 1'b1, 32'd0, got, rd);
    vectors++;
    if (rd !== 32'h0000_00A5) begin miscompares++; $display("FAIL store_readback: got %h want 000000a5", rd); end
    bus_op(32'h8000_0002, 1'b1, 1'b0, 32'hFFFF_FFFF, got, rd);
    bus_op(32'h8000_0002, 1'b0, 1'b1, 32'd0, got, rd);
    vectors++;
    if (rd !== 32'h00FF_FFFF) begin miscompares++; $display("FAIL period_zext: got %h want 00ffffff", rd); end
    bus_op(32'h8000_0002, 1'b1, 1'b0, 32'd0, got, rd);
  endtask

  task automatic test_unselected();
    logic got; logic [31:0] rd;
    bus_op(32'h8000_0004, 1'b0, 1'b1, 32'd0, got, rd);
    vectors++;
    if (got !== 1'b0 || rdata !== 32'd0) begin
      miscompares++; $display("FAIL unsel_load: ready %b rdata %h want 0/0", got, rdata);
    end
    bus_op(32'h0000_0010, 1'b1, 1'b0, 32'h0000_0033, got, rd);
    vectors++;
    if (got !== 1'b0) begin miscompares++; $display("FAIL unsel_store: ready %b want 0", got); end
    bus_op(32'h8000_0000, 1'b0, 1'b1, 32'd0, got, rd);
    vectors++;
    if (rd !== 32'h0000_00A5 || led !== 8'hA5) begin
      miscompares++; $display("FAIL unsel_unchanged: rdata %h led %h want a5/a5", rd, led);
    end
  endtask

  task automatic test_rd_wr_same();
    logic got; logic [31:0] rd;
    bus_op(32'h8000_0000, 1'b1, 1'b0, 32'h0000_0011, got, rd);
    bus_op(32'h8000_0000, 1'b1, 1'b1, 32'h0000_0022, got, rd);
    vectors++;
    if (rd !== 32'h0000_0011) begin miscompares++; $display("FAIL rdwr_old: got %h want 00000011", rd); end
    bus_op(32'h8000_0000, 1'b0, 1'b1, 32'd0, got, rd);
    vectors++;
    if (rd !== 32'h0000_0022) begin miscompares++; $display("FAIL rdwr_new: got %h want 00000022", rd); end
  endtask

  task automatic test_blink();
    logic got; logic [31:0] rd;
    logic [7:0] exp;
    int bad;
    bus_op(32'h8000_0000, 1'b1, 1'b0, 32'h0000_00FF, got, rd);
    bus_op(32'h8000_0001, 1'b1, 1'b0, 32'h0000_000F, got, rd);
    @(posedge clk); #1;
    vectors++;
    if (led !== 8'hFF) begin miscompares++; $display("FAIL blink_period0: got %h want ff", led); end
    bus_op(32'h8000_0002, 1'b1, 1'b0, 32'd10, got, rd);
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      exp = (((k - 1) / 10) % 2 == 0) ? 8'hFF : 8'hF0;
      vectors++;
      if (led !== exp) begin
        miscompares++; bad++;
        if (bad < 4) $display("FAIL blink_run k=%0d: got %h want %h", k, led, exp);
      end
    end
    bus_op(32'h8000_0002, 1'b1, 1'b0, 32'd10, got, rd);
    vectors++;
    if (led !== 8'hF0) begin miscompares++; $display("FAIL blink_rewrite_off: got %h want f0", led); end
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      exp = (((k - 1) / 10) % 2 == 0) ? 8'hFF : 8'hF0;
      vectors++;
      if (led !== exp) begin
        miscompares++; bad++;
        if (bad < 4) $display("FAIL blink_restart k=%0d: got %h want %h", k, led, exp);
      end
    end
    bus_op(32'h8000_0002, 1'b1, 1'b0, 32'd0, got, rd);
    @(posedge clk); #1;
    for (int k = 0; k < 30; k++) begin
      vectors++;
      if (led !== 8'hFF) begin
        miscompares++; bad++;
        if (bad < 4) $display("FAIL blink_stop k=%0d: got %h want ff", k, led);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_pwm();
    logic got; logic [31:0] rd;
    int lit;
    bus_op(32'h8000_0001, 1'b1, 1'b0, 32'd0, got, rd);
    bus_op(32'h8000_0003, 1'b1, 1'b0, 32'd64, got, rd);
    vectors++;
    if (got !== 1'b1) begin miscompares++; $display("FAIL duty_ack: got %b want 1", got); end
    @(posedge clk); #1;
    lit = 0;
    for (int k = 0; k < 256; k++) begin
      if (led === 8'hFF) lit++;
      @(posedge clk); #1;
    end
    vectors++;
`ifdef LED_PWM_EN
    if (lit !== 64) begin miscompares++; $display("FAIL pwm_duty64: lit %0d want 64", lit); end
`else
    if (lit !== 256) begin miscompares++; $display("FAIL nopwm_duty64: lit %0d want 256", lit); end
`endif
    bus_op(32'h8000_0003, 1'b1, 1'b0, 32'd0, got, rd);
    @(posedge clk); #1;
    lit = 0;
    for (int k = 0; k < 256; k++) begin
      if (led !== 8'h00) lit++;
      @(posedge clk); #1;
    end
    bus_op(32'h8000_0003, 1'b0, 1'b1, 32'd0, got, rd);
    vectors += 2;
`ifdef LED_PWM_EN
    if (lit !== 0) begin miscompares++; $display("FAIL pwm_duty0: lit %0d want 0", lit); end
    if (rd !== 32'd0) begin miscompares++; $display("FAIL pwm_duty_read: got %h want 0", rd); end
`else
    if (lit !== 256) begin miscompares++; $display("FAIL nopwm_duty0: lit %0d want 256", lit); end
    if (rd !== 32'h0000_00FF) begin miscompares++; $display("FAIL nopwm_duty_read: got %h want ff", rd); end
`endif
  endtask

  task automatic test_reset_mid_store();
    logic got; logic [31:0] rd;
    addr = 32'h8000_0000; write_en = 1'b1; wdata = 32'h0000_005A; reset = 1'b1;
    @(posedge clk); #1;
    write_en = 1'b0; reset = 1'b0;
    vectors++;
    if (ready !== 1'b0) begin miscompares++; $display("FAIL rst_store_ready: got %b want 0", ready); end
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b0 || led !== 8'h00) begin
      miscompares++; $display("FAIL rst_store_state: ready %b led %h want 0/00", ready, led);
    end
    bus_op(32'h8000_0000, 1'b0, 1'b1, 32'd0, got, rd);
    vectors++;
    if (rd !== 32'd0) begin miscompares++; $display("FAIL rst_store_data: got %h want 0", rd); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; addr = 32'd0; write_en = 1'b0; read_en = 1'b0; wdata = 32'd0;
    test_reset();
    test_store();
    test_unselected();
    test_rd_wr_same();
    test_blink();
    test_pwm();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
